tile_spawner: RTL and testbench

TILE_SPAWNER -- requirements
Module: tile_spawner

---
 rtl/tile_spawner.sv | 137 +++++++++++++
 tb/tb_tile_spawner.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_spawner.sv
// Purpose: spawns one 2/4 tile into a random empty cell of a 4x4 board, searching from an LFSR-chosen start cell.
// Latency: k+1 edges from the start edge to done, k = cells examined (1..16); matrix_out/full are registered.
// Backpressure: none; start is dropped while busy, seed_load is honoured in every state.
module tile_spawner #(
    parameter int TILE_W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          seed_load,
    input  logic [15:0]                   seed,
    input  logic [3:0][3:0][TILE_W-1:0]   matrix_in,
    output logic [3:0][3:0][TILE_W-1:0]   matrix_out,
    output logic                          done,
    output logic                          busy,
    output logic                          full
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    state_t                        state;
    state_t                        state_nxt;
    logic [15:0]                   lfsr;
    logic [3:0][3:0][TILE_W-1:0]   board;
    logic [3:0][3:0][TILE_W-1:0]   board_wr;
    logic [3:0]                    idx;
    logic [3:0]                    cnt;
    logic [TILE_W-1:0]             tile;
    logic                          cell_empty;
    logic                          scan_end;

    // Cell under examination this cycle and whether the scan finishes here
    // (either an empty slot was found or all 16 cells have been visited).
    assign cell_empty = (board[idx[3:2]][idx[1:0]] == '0);
    assign scan_end   = cell_empty || (cnt == 4'd15);

    // Board with the tile dropped into the current cell when it is empty;
    // on a full board this is the board unchanged.
    always_comb begin
        board_wr = board;
        if (cell_empty) begin
            board_wr[idx[3:2]][idx[1:0]] = tile;
        end
    end

    // Free-running Fibonacci LFSR; a seed load replaces the shift, and a zero
    // seed is swapped for the default so the register never locks up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_INIT;
        end else if (seed_load) begin
            lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs; done is the single DONE cycle.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, one-cell-per-cycle scan, and result registration.
    // idx/tile come from the LFSR value present before the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board      <= '0;
            matrix_out <= '0;
            idx        <= 4'd0;
            cnt        <= 4'd0;
            tile       <= '0;
            full       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        board <= matrix_in;
                        idx   <= lfsr[3:0];
                        cnt   <= 4'd0;
                        tile  <= (lfsr[7:4] == 4'd0) ? TILE_W'(4) : TILE_W'(2);
                        full  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (scan_end) begin
                        board      <= board_wr;
                        matrix_out <= board_wr;
                        full       <= !cell_empty;
                    end else begin
                        idx <= idx + 4'd1;
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_spawner.sv
// Purpose: randomized and directed checks of tile_spawner against a board-level reference model.
// Latency: measures edges from the start edge to done and compares with the model's cell count.
// Backpressure: exercises start-while-busy dropping and reset during a scan.
module tb_tile_spawner;

    localparam int W = 12;
    typedef logic [3:0][3:0][W-1:0] board_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        start     = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed      = 16'h0000;
    board_t      matrix_in = '0;
    board_t      matrix_out;
    logic        done;
    logic        busy;
    logic        full;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    tile_spawner #(.TILE_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .matrix_in  (matrix_in),
        .matrix_out (matrix_out),
        .done       (done),
        .busy       (busy),
        .full       (full)
    );

    // Reference random sequence: the value the next edge will sample.
    always @(posedge clk or negedge rst) begin
        if (!rst)           m_lfsr <= 16'hACE1;
        else if (seed_load) m_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
        else                m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Board-level model: walk from the start cell, first empty cell gets the tile.
    function automatic void model(input board_t b, input logic [15:0] l,
                                  output board_t eb, output logic ef, output int k);
        logic [W-1:0] t;
        int           i;
        t  = (l[7:4] == 4'd0) ? W'(4) : W'(2);
        eb = b;
        ef = 1'b1;
        k  = 16;
        for (int off = 0; off < 16; off++) begin
            i = (int'(l[3:0]) + off) % 16;
            if (b[2'(i / 4)][2'(i % 4)] == '0) begin
                eb[2'(i / 4)][2'(i % 4)] = t;
                ef = 1'b0;
                k  = off + 1;
                break;
            end
        end
    endfunction

    task automatic load_seed(input logic [15:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = s;
    endtask

    // One request; returns the model's expectation and the measured latency.
    task automatic run_req(input string name, input board_t b, output board_t eb,
                           output logic ef, output int k, output int lat);
        @(negedge clk);
        seed_load = 1'b0;
        matrix_in = b;
        start     = 1'b1;
        model(b, m_lfsr, eb, ef, k);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b want 1", name, busy);
        end
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (done !== 1'b1 || lat != k + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d (done=%b) want %0d", name, lat, done, k + 1);
        end
        vectors++;
        if (matrix_out !== eb) begin
            errors++;
            $display("FAIL %s board: got %h want %h", name, matrix_out, eb);
        end
        vectors++;
        if (full !== ef) begin
            errors++;
            $display("FAIL %s full: got %b want %b", name, full, ef);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: got done=%b busy=%b want 0 0", name, done, busy);
        end
        vectors++;
        if (matrix_out !== eb) begin
            errors++;
            $display("FAIL %s hold: got %h want %h", name, matrix_out, eb);
        end
    endtask

    task automatic test_reset();
        board_t eb, want;
        logic   ef;
        int     k, lat;
        repeat (3) @(negedge clk);
        vectors++;
        if (matrix_out !== '0 || done !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out=%h done=%b busy=%b full=%b want all 0",
                     matrix_out, done, busy, full);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        run_req("reset_lfsr", '0, eb, ef, k, lat);
        want       = '0;
        want[0][1] = W'(2);
        vectors++;
        if (matrix_out !== want || lat != 2) begin
            errors++;
            $display("FAIL reset_lfsr_cell: got %h lat %0d want %h lat 2", matrix_out, lat, want);
        end
    endtask

    task automatic test_seed_empty();
        board_t eb, want;
        logic   ef;
        int     k, lat;
        load_seed(16'h0003);
        run_req("seed3", '0, eb, ef, k, lat);
        want       = '0;
        want[0][3] = W'(4);
        vectors++;
        if (matrix_out !== want || lat != 2 || full !== 1'b0) begin
            errors++;
            $display("FAIL seed3_direct: got %h lat %0d full %b want %h lat 2 full 0",
                     matrix_out, lat, full, want);
        end
    endtask

    task automatic test_skip_and_wrap();
        board_t b, eb, want;
        logic   ef;
        int     k, lat;
        b       = '0;
        b[1][1] = W'(8);
        b[1][2] = W'(16);
        want       = b;
        want[1][3] = W'(2);
        load_seed(16'h0015);
        run_req("skip", b, eb, ef, k, lat);
        vectors++;
        if (matrix_out !== want || lat != 4) begin
            errors++;
            $display("FAIL skip_direct: got %h lat %0d want %h lat 4", matrix_out, lat, want);
        end
        b       = '0;
        b[3][2] = W'(32);
        b[3][3] = W'(32);
        want       = b;
        want[0][0] = W'(2);
        load_seed(16'h001E);
        run_req("wrap", b, eb, ef, k, lat);
        vectors++;
        if (matrix_out !== want || lat != 4) begin
            errors++;
            $display("FAIL wrap_direct: got %h lat %0d want %h lat 4", matrix_out, lat, want);
        end
    endtask

    task automatic test_full_board();
        int     fb[16] = '{2, 4, 32, 64, 16, 32, 16, 128, 4, 2, 8, 32, 8, 4, 2, 16};
        board_t b, eb;
        logic   ef;
        int     k, lat;
        for (int i = 0; i < 16; i++) b[2'(i / 4)][2'(i % 4)] = W'(fb[i]);
        load_seed(16'($urandom));
        run_req("full", b, eb, ef, k, lat);
        vectors++;
        if (matrix_out !== b || full !== 1'b1 || lat != 17) begin
            errors++;
            $display("FAIL full_direct: got %h full %b lat %0d want %h full 1 lat 17",
                     matrix_out, full, lat, b);
        end
    endtask

    task automatic test_back_to_back();
        board_t b, eb, got;
        logic   ef;
        int     k, nd, hole;
        @(negedge clk);
        seed_load = 1'b0;
        b         = '0;
        for (int i = 0; i < 16; i++) b[2'(i / 4)][2'(i % 4)] = W'(2);
        hole = (int'(m_lfsr[3:0]) + 6) % 16;
        b[2'(hole / 4)][2'(hole % 4)] = '0;
        matrix_in = b;
        start     = 1'b1;
        model(b, m_lfsr, eb, ef, k);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        matrix_in = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd    = 0;
        got   = '0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                got = matrix_out;
            end
        end
        vectors++;
        if (nd != 1) begin
            errors++;
            $display("FAIL busy_start_count: got %0d done pulses want 1", nd);
        end
        vectors++;
        if (got !== eb || matrix_out !== eb) begin
            errors++;
            $display("FAIL busy_start_board: got %h want %h", got, eb);
        end
    endtask

    task automatic test_reset_mid_scan();
        int     fb[16] = '{2, 4, 32, 64, 16, 32, 16, 128, 4, 2, 8, 32, 8, 4, 2, 16};
        board_t b, eb;
        logic   ef;
        int     k, lat, nd;
        for (int i = 0; i < 16; i++) b[2'(i / 4)][2'(i % 4)] = W'(fb[i]);
        @(negedge clk);
        seed_load = 1'b0;
        matrix_in = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (matrix_out !== '0 || done !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL midscan_reset: got out=%h done=%b busy=%b full=%b want all 0",
                     matrix_out, done, busy, full);
        end
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b1;
            if (done === 1'b1) nd++;
        end
        vectors++;
        if (nd != 0) begin
            errors++;
            $display("FAIL midscan_no_done: got %0d done pulses want 0", nd);
        end
        b       = '0;
        b[0][0] = W'(64);
        run_req("after_reset", b, eb, ef, k, lat);
    endtask

    task automatic test_random();
        board_t b, eb;
        logic   ef;
        int     k, lat, thr;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_seed(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            thr = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 15) < thr) b[2'(i / 4)][2'(i % 4)] = '0;
                else b[2'(i / 4)][2'(i % 4)] = W'(1 << $urandom_range(1, 11));
            end
            run_req("random", b, eb, ef, k, lat);
        end
    endtask

    initial begin
        test_reset();
        test_seed_empty();
        test_skip_and_wrap();
        test_full_board();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
